bmp_upload_reader: RTL and testbench

- Read-side counterpart of the BMP download path in the MENU core.
- During a data_io upload (ioctl_upload=1), serves a complete 32bpp BMP file byte by byte on ioctl_din.
- Bytes 0..53 are a generated header. Bytes 54.. are read from the SDRAM framebuffer over the sdram port1 toggle handshake.
- Sits between data_io and sdram port1, muxed with the download writer. Runs on clk_sys (the clk_ram domain).

---
 rtl/bmp_upload_reader.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_bmp_upload_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_upload_reader.sv
// bmp_upload_reader
//   Serves a complete 32bpp BMP file byte by byte to data_io during an upload.
//   Offsets 0..53 come from a generated header. Pixel bytes are fetched from
//   the SDRAM framebuffer over the port1 toggle handshake and held in a
//   one-word buffer. When an odd byte lane is consumed, the next word is
//   prefetched so that a sequential stream does not stall.
//
// Ports
//   clk_sys        system clock (clk_ram domain)
//   reset_n        asynchronous active-low reset
//   ioctl_upload   upload active
//   ioctl_addr     file byte offset requested
//   ioctl_rd       strobe: byte at ioctl_addr consumed
//   ioctl_din      byte for ioctl_addr
//   din_ready      ioctl_din is valid for the current ioctl_addr
//   port1_req      sdram request toggle
//   port1_ack      sdram ack toggle (request complete when equal to port1_req)
//   port1_a        sdram word address
//   port1_ds       byte strobes (always both)
//   port1_we       write enable (always 0)
//   port1_q        sdram read word
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no upload; buffer invalid, din_ready low
// EVAL    | decode ioctl_addr: header/past-end, buffer hit, or fetch
// REQ     | toggle port1_req for the demand word
// WAIT    | wait for ack, fill buffer, select lane
// SERVE   | byte valid; re-evaluate on address change, prefetch on odd rd
// PREF    | toggle port1_req for word+1, current byte still presented
// PWAIT   | wait for prefetch ack, refresh buffer

module bmp_upload_reader #(
    parameter int WIDTH     = 512,
    parameter int HEIGHT    = 312,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_upload,
    input  logic [24:0] ioctl_addr,
    input  logic        ioctl_rd,
    output logic [7:0]  ioctl_din,
    output logic        din_ready,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic        port1_we,
    input  logic [15:0] port1_q
);

    localparam logic [31:0] IMG     = 32'(WIDTH * HEIGHT * 4);
    localparam logic [31:0] FSIZE   = IMG + 32'd54;
    localparam logic [24:0] FSIZE_A = FSIZE[24:0];
    localparam logic [23:0] BASE_B  = 24'(BASE_ADDR);
    localparam logic [31:0] W32     = 32'(WIDTH);
    localparam logic [31:0] H32     = 32'(HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_REQ,
        S_WAIT,
        S_SERVE,
        S_PREF,
        S_PWAIT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  din_q, din_d;
    logic        rdy_q, rdy_d;
    logic        req_q, req_d;
    logic [22:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [22:0] tag_q, tag_d;
    logic        valid_q, valid_d;
    logic [24:0] last_q, last_d;
    logic        eval_now;

    // Header byte lookup: each field is selected by offset range, then the
    // little-endian byte within the field is shifted out.
    function automatic logic [7:0] hdr_byte(input logic [5:0] off);
        logic [31:0] f;
        logic [1:0]  k;
        f = 32'd0;
        k = 2'd0;
        if (off < 6'd2) begin
            f = 32'h0000_4D42;
            k = off[1:0];
        end else if (off < 6'd6) begin
            f = FSIZE;
            k = 2'(off - 6'd2);
        end else if (off < 6'd10) begin
            f = 32'd0;
        end else if (off < 6'd14) begin
            f = 32'd54;
            k = 2'(off - 6'd10);
        end else if (off < 6'd18) begin
            f = 32'd40;
            k = 2'(off - 6'd14);
        end else if (off < 6'd22) begin
            f = W32;
            k = 2'(off - 6'd18);
        end else if (off < 6'd26) begin
            f = H32;
            k = 2'(off - 6'd22);
        end else if (off < 6'd30) begin
            // planes (16 bits) followed by bit count (16 bits)
            f = {16'd32, 16'd1};
            k = 2'(off - 6'd26);
        end else if (off < 6'd34) begin
            f = 32'd0;
        end else if (off < 6'd38) begin
            f = IMG;
            k = 2'(off - 6'd34);
        end else if (off < 6'd46) begin
            f = 32'd2835;
            k = 2'(off - 6'd38);
        end else begin
            f = 32'd0;
        end
        return 8'(f >> {k, 3'b000});
    endfunction

    // Decode of the incoming address (used when evaluating)
    logic        e_hdr, e_end, e_lane, e_hit;
    logic [23:0] e_b;
    logic [22:0] e_word;

    assign e_hdr  = ioctl_addr < 25'd54;
    assign e_end  = ioctl_addr >= FSIZE_A;
    assign e_b    = BASE_B + ioctl_addr[23:0] - 24'd54;
    assign e_word = e_b[23:1];
    assign e_lane = e_b[0];
    assign e_hit  = valid_q && (tag_q == e_word);

    // Decode of the address currently being served
    logic        c_pix, c_lane, c_pf_ok;
    logic [23:0] c_b;
    logic [22:0] c_word;

    assign c_b     = BASE_B + last_q[23:0] - 24'd54;
    assign c_word  = c_b[23:1];
    assign c_lane  = c_b[0];
    assign c_pix   = (last_q >= 25'd54) && (last_q < FSIZE_A);
    // word+1 only holds file data if the next offset is still inside the file
    assign c_pf_ok = ({1'b0, last_q} + 26'd1) < {1'b0, FSIZE_A};

    logic chg;
    assign chg = ioctl_addr != last_q;

    always_comb begin
        state_d  = state_q;
        din_d    = din_q;
        rdy_d    = rdy_q;
        req_d    = req_q;
        addr_d   = addr_q;
        data_d   = data_q;
        tag_d    = tag_q;
        valid_d  = valid_q;
        last_d   = last_q;
        eval_now = 1'b0;

        case (state_q)
            S_IDLE: begin
                rdy_d   = 1'b0;
                valid_d = 1'b0;
                if (ioctl_upload) state_d = S_EVAL;
            end
            S_EVAL: begin
                if (!ioctl_upload) begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b0;
                    valid_d = 1'b0;
                end else begin
                    eval_now = 1'b1;
                end
            end
            S_REQ: begin
                if (!ioctl_upload) begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b0;
                    valid_d = 1'b0;
                end else begin
                    req_d   = ~req_q;
                    addr_d  = c_word;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (port1_ack == req_q) begin
                    if (!ioctl_upload) begin
                        state_d = S_IDLE;
                        rdy_d   = 1'b0;
                        valid_d = 1'b0;
                    end else begin
                        data_d  = port1_q;
                        tag_d   = addr_q;
                        valid_d = 1'b1;
                        din_d   = c_lane ? port1_q[15:8] : port1_q[7:0];
                        rdy_d   = 1'b1;
                        state_d = S_SERVE;
                    end
                end
            end
            S_SERVE: begin
                if (!ioctl_upload) begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b0;
                    valid_d = 1'b0;
                end else if (chg) begin
                    // evaluate in place so a buffer hit costs a single cycle
                    eval_now = 1'b1;
                end else if (ioctl_rd && c_pix && c_lane && c_pf_ok) begin
                    state_d = S_PREF;
                end
            end
            S_PREF: begin
                if (!ioctl_upload) begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b0;
                    valid_d = 1'b0;
                end else begin
                    req_d   = ~req_q;
                    addr_d  = c_word + 23'd1;
                    state_d = S_PWAIT;
                end
            end
            S_PWAIT: begin
                if (port1_ack == req_q) begin
                    if (!ioctl_upload) begin
                        state_d = S_IDLE;
                        rdy_d   = 1'b0;
                        valid_d = 1'b0;
                    end else begin
                        data_d  = port1_q;
                        tag_d   = addr_q;
                        valid_d = 1'b1;
                        if (chg) begin
                            rdy_d   = 1'b0;
                            state_d = S_EVAL;
                        end else begin
                            state_d = S_SERVE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                rdy_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase

        if (eval_now) begin
            last_d = ioctl_addr;
            if (e_hdr || e_end) begin
                din_d   = e_hdr ? hdr_byte(ioctl_addr[5:0]) : 8'h00;
                rdy_d   = 1'b1;
                state_d = S_SERVE;
            end else if (e_hit) begin
                din_d   = e_lane ? data_q[15:8] : data_q[7:0];
                rdy_d   = 1'b1;
                state_d = S_SERVE;
            end else begin
                rdy_d   = 1'b0;
                state_d = S_REQ;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            din_q   <= 8'h00;
            rdy_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= 23'd0;
            data_q  <= 16'h0000;
            tag_q   <= 23'd0;
            valid_q <= 1'b0;
            last_q  <= 25'd0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            rdy_q   <= rdy_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // A pending address change invalidates the presented byte immediately.
    assign din_ready = rdy_q & ~chg;
    assign ioctl_din = din_q;
    assign port1_req = req_q;
    assign port1_a   = addr_q;
    assign port1_ds  = 2'b11;
    assign port1_we  = 1'b0;

endmodule

// File: tb/tb_bmp_upload_reader.sv
module tb_bmp_upload_reader;

    logic        clk_sys;
    logic        reset_n;
    logic        ioctl_upload;
    logic [24:0] ioctl_addr;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din;
    logic        din_ready;
    logic        port1_req;
    logic        port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic        port1_we;
    logic [15:0] port1_q;

    bmp_upload_reader dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ioctl_upload (ioctl_upload),
        .ioctl_addr   (ioctl_addr),
        .ioctl_rd     (ioctl_rd),
        .ioctl_din    (ioctl_din),
        .din_ready    (din_ready),
        .port1_req    (port1_req),
        .port1_ack    (port1_ack),
        .port1_a      (port1_a),
        .port1_ds     (port1_ds),
        .port1_we     (port1_we),
        .port1_q      (port1_q)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    // ---------------- sdram model ----------------
    int  ack_delay = 3;
    int  dly_cnt;
    logic busy;

    function automatic logic [15:0] mem_word(input logic [22:0] w);
        if (w == 23'd0) return 16'h2211;
        if (w == 23'd1) return 16'h4433;
        return {w[7:0] ^ 8'h5A ^ {1'b0, w[22:16]}, w[15:8]};
    endfunction

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            port1_ack <= 1'b0;
            port1_q   <= 16'h0000;
            busy      <= 1'b0;
            dly_cnt   <= 0;
        end else if (!busy && (port1_req != port1_ack)) begin
            busy    <= 1'b1;
            dly_cnt <= ack_delay;
        end else if (busy) begin
            if (dly_cnt <= 1) begin
                port1_q   <= mem_word(port1_a);
                port1_ack <= port1_req;
                busy      <= 1'b0;
            end else begin
                dly_cnt <= dly_cnt - 1;
            end
        end
    end

    // ---------------- request monitor ----------------
    int          req_cnt = 0;
    int          viol    = 0;
    logic [22:0] last_req_a = '0;
    logic        prev_req, prev_ack;

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prev_req <= 1'b0;
            prev_ack <= 1'b0;
        end else begin
            if (port1_req !== prev_req) begin
                req_cnt++;
                last_req_a = port1_a;
                if (prev_req !== prev_ack) viol++;
            end
            prev_req <= port1_req;
            prev_ack <= port1_ack;
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    string      nm_q[$];
    int         issued  = 0;
    int         checked = 0;

    always @(negedge clk_sys) begin
        if (reset_n && din_ready && (checked < issued)) begin
            logic [7:0] e;
            string      n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            total++;
            if (ioctl_din !== e) begin
                bad++;
                $display("FAIL %s: ioctl_din got %02h expected %02h", n, ioctl_din, e);
            end
            checked++;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic issue(input logic [24:0] a, input logic [7:0] e, input string nm);
        @(posedge clk_sys);
        #1;
        ioctl_addr   = a;
        ioctl_upload = 1'b1;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        issued++;
    endtask

    task automatic issue_nochk(input logic [24:0] a);
        @(posedge clk_sys);
        #1;
        ioctl_addr   = a;
        ioctl_upload = 1'b1;
    endtask

    task automatic wait_served(output int lat);
        lat = 0;
        while ((checked < issued) && (lat < 200)) begin
            @(negedge clk_sys);
            #2;
            lat++;
        end
        if (checked < issued) begin
            total++;
            bad++;
            $display("FAIL timeout: din_ready not seen for offset %0d", ioctl_addr);
            void'(exp_q.pop_front());
            void'(nm_q.pop_front());
            checked = issued;
        end
    endtask

    task automatic pulse_rd();
        @(posedge clk_sys);
        #1;
        ioctl_rd = 1'b1;
        @(posedge clk_sys);
        #1;
        ioctl_rd = 1'b0;
    endtask

    logic [7:0] hdr_exp [54];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int snap;
        logic r1;

        hdr_exp = '{8'h42, 8'h4D, 8'h36, 8'hC0, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h36, 8'h00, 8'h00, 8'h00, 8'h28, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
                    8'h00, 8'h00, 8'h38, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h20, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'h09, 8'h00, 8'h13, 8'h0B,
                    8'h00, 8'h00, 8'h13, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00};

        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_addr   = '0;
        ioctl_rd     = 1'b0;
        cycles(3);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_ioctl_din", ioctl_din, 0);
        chk("rst_port1_req", port1_req, 0);
        chk("rst_port1_a",   port1_a,   0);
        chk("port1_ds",      port1_ds,  2'b11);
        chk("port1_we",      port1_we,  0);
        reset_n = 1'b1;
        cycles(2);

        // header
        for (int i = 0; i < 54; i++) begin
            issue(25'(i), hdr_exp[i], $sformatf("hdr%0d", i));
            wait_served(lat);
            pulse_rd();
        end
        chk("hdr_no_req", req_cnt, 0);

        // pixels 54..57
        issue(25'd54, 8'h11, "pix54");
        wait_served(lat);
        chk("pix54_req_cnt", req_cnt, 1);
        chk("pix54_req_word", last_req_a, 0);
        pulse_rd();
        issue(25'd55, 8'h22, "pix55");
        wait_served(lat);
        chk("pix55_no_pref_before_rd", req_cnt, 1);
        pulse_rd();
        issue(25'd56, 8'h33, "pix56");
        wait_served(lat);
        chk("pix56_pref_cnt", req_cnt, 2);
        chk("pix56_pref_word", last_req_a, 1);
        pulse_rd();
        issue(25'd57, 8'h44, "pix57");
        wait_served(lat);
        chk("pix57_hit_latency", lat, 2);
        chk("pix57_no_req", req_cnt, 2);
        pulse_rd();
        cycles(10);

        // upload dropped while waiting for a slow ack
        ack_delay = 20;
        issue_nochk(25'd1054);
        cycles(5);
        ioctl_upload = 1'b0;
        snap = req_cnt;
        cycles(30);
        chk("drop_no_toggle", req_cnt, snap);
        chk("drop_handshake_idle", port1_req, port1_ack);
        chk("drop_din_ready", din_ready, 0);

        // re-upload offset 54 with a 20-cycle ack: fresh request, stall
        issue(25'd54, 8'h11, "reup54");
        cycles(8);
        chk("slow_ready_low_a", din_ready, 0);
        r1 = port1_req;
        cycles(8);
        chk("slow_req_stable", port1_req, r1);
        chk("slow_ready_low_b", din_ready, 0);
        wait_served(lat);
        chk("reup_req_cnt", req_cnt, snap + 1);
        chk("reup_req_word", last_req_a, 0);
        ack_delay = 2;
        pulse_rd();

        // past-end offset and last pixel
        snap = req_cnt;
        issue(25'd639030, 8'h00, "fsize");
        wait_served(lat);
        chk("fsize_no_req", req_cnt, snap);
        pulse_rd();
        issue(25'd639029, 8'hA1, "lastpix");
        wait_served(lat);
        pulse_rd();
        cycles(10);
        chk("lastpix_req_cnt", req_cnt, snap + 1);
        chk("lastpix_word", last_req_a, 23'd319487);

        // reset in the middle of a request
        ack_delay = 20;
        issue_nochk(25'd2054);
        cycles(5);
        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        #1;
        chk("rst_mid_din_ready", din_ready, 0);
        chk("rst_mid_ioctl_din", ioctl_din, 0);
        chk("rst_mid_req",       port1_req, 0);
        chk("rst_mid_a",         port1_a,   0);
        cycles(3);
        reset_n = 1'b1;
        cycles(3);
        chk("post_rst_ready", din_ready, 0);
        ack_delay = 2;
        snap = req_cnt;
        issue(25'd54, 8'h11, "postrst54");
        wait_served(lat);
        chk("postrst_fresh_req", req_cnt, snap + 1);
        pulse_rd();
        cycles(5);

        chk("handshake_violations", viol, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
